// File: rtl/pmci_vdm_tx_pkg.sv
// Shared constants and types for the multi-channel VDM TX packet buffer.
// Covers the CSR map, FCR bit positions, STS layout and the packet descriptor.
package pmci_vdm_tx_pkg;

  localparam logic [3:0]  FCR_OFF       = 4'h0;
  localparam logic [3:0]  PDR_OFF       = 4'h8;
  localparam logic [31:0] CH_WIN_END    = 32'h100;
  localparam logic [31:0] STS_ADDR      = 32'h100;
  localparam logic [31:0] DROP_CNT_ADDR = 32'h104;
  localparam logic [31:0] IRQ_MASK_ADDR = 32'h108;

  localparam int FCR_COMMIT_BIT = 0;
  localparam int FCR_ABORT_BIT  = 1;

  typedef struct packed {
    logic [7:0] qfull;
    logic [7:0] bad_commit;
    logic [7:0] ovf;
  } sts_t;

  typedef struct packed {
    logic [15:0] len;
  } desc_t;

  function automatic logic [31:0] fcr_word(input logic [15:0] free_dw,
                                           input logic [7:0] q_cnt,
                                           input logic pend);
    return {pend, 7'b0, q_cnt, free_dw};
  endfunction

endpackage

// File: rtl/pmci_vdm_ch_fifo.sv
// One VDM TX channel: dword RAM with uncommitted/committed/read pointers and
// a descriptor queue of committed packet lengths.
module pmci_vdm_ch_fifo
  import pmci_vdm_tx_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int MAX_PKT_DW = 64,
  parameter int PKT_Q      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pdr_wr,
  input  logic [31:0] pdr_data,
  input  logic        commit,
  input  logic        abort,
  input  logic        pop_dw,
  input  logic        issue,
  input  logic        retire,
  output logic [31:0] rd_data,
  output logic [15:0] head_len,
  output logic        pkt_avail,
  output logic [15:0] free_dw,
  output logic [7:0]  q_cnt,
  output logic        pend,
  output logic        ovf_evt,
  output logic        bad_commit_evt,
  output logic        qfull_evt,
  output logic        drop_evt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int QAW = $clog2(PKT_Q);
  localparam int QW  = QAW + 1;

  logic [31:0]   mem [DEPTH];
  desc_t         dq  [PKT_Q];
  logic [PW-1:0] wr_ptr, cmt_ptr, rd_ptr, used;
  logic [QW-1:0] q_wp, q_ip, q_rp, q_used;
  logic [15:0]   pend_len;
  logic          bad, full, q_full, at_max;
  logic          pdr_ok, commit_go, push, rollback;

  assign used      = wr_ptr - rd_ptr;
  assign full      = (used == PW'(DEPTH));
  assign q_used    = q_wp - q_rp;
  assign q_full    = (q_used == QW'(PKT_Q));
  assign at_max    = (pend_len == 16'(MAX_PKT_DW));

  assign pdr_ok         = pdr_wr && !full && !at_max;
  assign ovf_evt        = pdr_wr && !pdr_ok;
  assign commit_go      = commit && !abort;
  assign bad_commit_evt = commit_go && !bad && (pend_len == '0);
  assign qfull_evt      = commit_go && !bad && (pend_len != '0) && q_full;
  assign drop_evt       = commit_go && (bad || ((pend_len != '0) && q_full));
  assign push           = commit_go && !bad && (pend_len != '0) && !q_full;
  assign rollback       = abort || drop_evt;

  // Descriptors are issued when the packet's first dword leaves the RAM and
  // retired only when its last dword is accepted downstream, so a packet
  // stalled in the output register still occupies a queue slot.
  assign rd_data   = mem[rd_ptr[AW-1:0]];
  assign head_len  = dq[q_ip[QAW-1:0]].len;
  assign pkt_avail = (q_wp != q_ip);
  assign free_dw   = 16'(PW'(DEPTH) - used);
  assign q_cnt     = 8'(q_used);
  assign pend      = (pend_len != '0) || bad;

  always_ff @(posedge clk) begin
    if (pdr_ok) mem[wr_ptr[AW-1:0]] <= pdr_data;
  end

  always_ff @(posedge clk) begin
    if (push) dq[q_wp[QAW-1:0]] <= '{len: pend_len};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      rd_ptr   <= '0;
      q_wp     <= '0;
      q_ip     <= '0;
      q_rp     <= '0;
      pend_len <= '0;
      bad      <= 1'b0;
    end else begin
      if (pdr_ok) begin
        wr_ptr   <= wr_ptr + 1'b1;
        pend_len <= pend_len + 16'd1;
      end else if (pdr_wr) begin
        bad <= 1'b1;
      end
      if (push) begin
        q_wp     <= q_wp + 1'b1;
        cmt_ptr  <= wr_ptr;
        pend_len <= '0;
        bad      <= 1'b0;
      end
      if (rollback) begin
        wr_ptr   <= cmt_ptr;
        pend_len <= '0;
        bad      <= 1'b0;
      end
      if (pop_dw) rd_ptr <= rd_ptr + 1'b1;
      if (issue)  q_ip   <= q_ip + 1'b1;
      if (retire) q_rp   <= q_rp + 1'b1;
    end
  end

endmodule

// File: rtl/pmci_vdm_mch_tx_buf.sv
// Multi-channel VDM TX buffer: CSR decode, STS/DROP_CNT/IRQ, packet-granular
// round-robin arbiter and the registered output stream stage.
module pmci_vdm_mch_tx_buf
  import pmci_vdm_tx_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 128,
  parameter int MAX_PKT_DW = 64,
  parameter int PKT_Q      = 4,
  parameter int CSR_AW     = 12,
  localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              csr_wr,
  input  logic              csr_rd,
  input  logic [CSR_AW-1:0] csr_addr,
  input  logic [31:0]       csr_wdata,
  output logic [31:0]       csr_rdata,
  output logic              csr_rvalid,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [31:0]       tx_data,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [CHW-1:0]    tx_ch,
  output logic              err_irq
);

  logic [31:0] ch_rd_data  [NUM_CH];
  logic [15:0] ch_head_len [NUM_CH];
  logic [15:0] ch_free     [NUM_CH];
  logic [7:0]  ch_qcnt     [NUM_CH];
  logic [NUM_CH-1:0] ch_pend, pkt_avail, pdr_wr, fcr_wr, pop_dw, issue, retire;
  logic [NUM_CH-1:0] ovf_evt, badc_evt, qfull_evt, drop_evt;

  logic [31:0] addr32, rd_mux;
  logic [3:0]  ch_sel, off;
  logic        ch_ok;
  sts_t        sts, sts_evt, sts_next;
  logic [23:0] w1c, irq_mask;
  logic [15:0] drop_cnt;
  logic        unused_wdata;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pmci_vdm_ch_fifo #(
      .DEPTH(DEPTH), .MAX_PKT_DW(MAX_PKT_DW), .PKT_Q(PKT_Q)
    ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .pdr_wr        (pdr_wr[g]),
      .pdr_data      (csr_wdata),
      .commit        (fcr_wr[g] & csr_wdata[FCR_COMMIT_BIT]),
      .abort         (fcr_wr[g] & csr_wdata[FCR_ABORT_BIT]),
      .pop_dw        (pop_dw[g]),
      .issue         (issue[g]),
      .retire        (retire[g]),
      .rd_data       (ch_rd_data[g]),
      .head_len      (ch_head_len[g]),
      .pkt_avail     (pkt_avail[g]),
      .free_dw       (ch_free[g]),
      .q_cnt         (ch_qcnt[g]),
      .pend          (ch_pend[g]),
      .ovf_evt       (ovf_evt[g]),
      .bad_commit_evt(badc_evt[g]),
      .qfull_evt     (qfull_evt[g]),
      .drop_evt      (drop_evt[g])
    );
  end

  assign addr32       = 32'(csr_addr);
  assign ch_sel       = csr_addr[7:4];
  assign off          = csr_addr[3:0];
  assign ch_ok        = (addr32 < CH_WIN_END) && (32'(ch_sel) < NUM_CH);
  assign unused_wdata = ^csr_wdata[31:24];

  always_comb begin
    pdr_wr = '0;
    fcr_wr = '0;
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_ok && (ch_sel == 4'(i))) begin
        pdr_wr[i] = csr_wr && (off == PDR_OFF);
        fcr_wr[i] = csr_wr && (off == FCR_OFF);
        if (off == FCR_OFF) rd_mux = fcr_word(ch_free[i], ch_qcnt[i], ch_pend[i]);
      end
    end
    if (addr32 == STS_ADDR)      rd_mux = {8'b0, sts};
    if (addr32 == DROP_CNT_ADDR) rd_mux = {16'b0, drop_cnt};
    if (addr32 == IRQ_MASK_ADDR) rd_mux = {8'b0, irq_mask};
  end

  // A new error event in the same cycle as its W1C keeps the bit set.
  always_comb begin
    sts_evt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sts_evt.ovf[i]        = ovf_evt[i];
      sts_evt.bad_commit[i] = badc_evt[i];
      sts_evt.qfull[i]      = qfull_evt[i];
    end
    w1c      = (csr_wr && (addr32 == STS_ADDR)) ? csr_wdata[23:0] : '0;
    sts_next = sts_t'((sts & ~w1c) | sts_evt);
  end

  assign err_irq = |(sts & ~irq_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      csr_rvalid <= 1'b0;
      csr_rdata  <= '0;
      sts        <= '0;
      drop_cnt   <= '0;
      irq_mask   <= '0;
    end else begin
      csr_rvalid <= csr_rd;
      csr_rdata  <= csr_rd ? rd_mux : '0;
      sts        <= sts_next;
      if (csr_wr && (addr32 == DROP_CNT_ADDR)) drop_cnt <= '0;
      else if ((|drop_evt) && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      if (csr_wr && (addr32 == IRQ_MASK_ADDR)) irq_mask <= csr_wdata[23:0];
    end
  end

  // Stream handshake: a dword moves when tx_valid && tx_ready at a rising edge.
  // tx_valid never drops and no tx_* field changes while tx_valid && !tx_ready;
  // the register reloads whenever it is empty or being accepted.
  logic           busy, n_busy, load, arb_found;
  logic [15:0]    rem, n_rem;
  logic [CHW-1:0] gnt_ch, n_gnt, rr_ptr, n_rr, arb_ch;
  logic           n_valid, n_sop, n_eop;
  logic [31:0]    n_data;
  logic [CHW-1:0] n_ch;

  function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] c);
    return (32'(c) == NUM_CH - 1) ? '0 : c + 1'b1;
  endfunction

  always_comb begin
    int c;
    arb_found = 1'b0;
    arb_ch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(rr_ptr) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!arb_found && pkt_avail[c]) begin
        arb_found = 1'b1;
        arb_ch    = CHW'(c);
      end
    end
  end

  assign load = !tx_valid || tx_ready;

  always_comb begin
    pop_dw  = '0;
    issue   = '0;
    n_valid = 1'b0;
    n_data  = '0;
    n_sop   = 1'b0;
    n_eop   = 1'b0;
    n_ch    = '0;
    n_busy  = busy;
    n_rem   = rem;
    n_gnt   = gnt_ch;
    n_rr    = rr_ptr;
    if (load) begin
      if (busy) begin
        n_valid        = 1'b1;
        n_ch           = gnt_ch;
        n_data         = ch_rd_data[gnt_ch];
        n_eop          = (rem == 16'd1);
        pop_dw[gnt_ch] = 1'b1;
        n_rem          = rem - 16'd1;
        if (rem == 16'd1) begin
          n_busy = 1'b0;
          n_rr   = next_ch(gnt_ch);
        end
      end else if (arb_found) begin
        n_valid        = 1'b1;
        n_ch           = arb_ch;
        n_data         = ch_rd_data[arb_ch];
        n_sop          = 1'b1;
        n_eop          = (ch_head_len[arb_ch] == 16'd1);
        pop_dw[arb_ch] = 1'b1;
        issue[arb_ch]  = 1'b1;
        if (ch_head_len[arb_ch] == 16'd1) begin
          n_rr = next_ch(arb_ch);
        end else begin
          n_busy = 1'b1;
          n_rem  = ch_head_len[arb_ch] - 16'd1;
          n_gnt  = arb_ch;
        end
      end
    end
  end

  always_comb begin
    retire = '0;
    for (int i = 0; i < NUM_CH; i++)
      retire[i] = tx_valid && tx_ready && tx_eop && (tx_ch == CHW'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b0;
      tx_ch    <= '0;
      busy     <= 1'b0;
      rem      <= '0;
      gnt_ch   <= '0;
      rr_ptr   <= '0;
    end else begin
      if (load) begin
        tx_valid <= n_valid;
        tx_data  <= n_data;
        tx_sop   <= n_sop;
        tx_eop   <= n_eop;
        tx_ch    <= n_ch;
      end
      busy   <= n_busy;
      rem    <= n_rem;
      gnt_ch <= n_gnt;
      rr_ptr <= n_rr;
    end
  end

endmodule

// File: tb/tb_pmci_vdm_mch_tx_buf.sv
// Directed bench for pmci_vdm_mch_tx_buf: CSR driver tasks, a stream monitor
// popping an expected-dword queue, and one summary line at the end.
module tb_pmci_vdm_mch_tx_buf;

  localparam int W = 35;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_wr = 1'b0;
  logic        csr_rd = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        csr_rvalid;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] tx_data;
  logic        tx_sop;
  logic        tx_eop;
  logic [0:0]  tx_ch;
  logic        err_irq;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  pmci_vdm_mch_tx_buf dut (
    .clk       (clk),
    .reset     (reset),
    .csr_wr    (csr_wr),
    .csr_rd    (csr_rd),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata),
    .csr_rvalid(csr_rvalid),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_sop    (tx_sop),
    .tx_eop    (tx_eop),
    .tx_ch     (tx_ch),
    .err_irq   (err_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] fcr_a(input int ch);
    return 12'(ch * 16);
  endfunction

  function automatic logic [11:0] pdr_a(input int ch);
    return 12'(ch * 16 + 8);
  endfunction

  function automatic logic [W-1:0] ent(input int ch, input logic sop, input logic eop,
                                       input logic [31:0] d);
    return {ch[0], sop, eop, d};
  endfunction

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_wr    = 1'b1;
    tick();
    csr_wr    = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    csr_rd   = 1'b1;
    tick();
    csr_rd   = 1'b0;
    check("csr_rvalid", 64'(csr_rvalid), 64'd1);
    d = csr_rdata;
  endtask

  task automatic send_pkt(input int ch, input int n, input logic [31:0] base,
                          input bit expect_out);
    for (int i = 0; i < n; i++) begin
      if (expect_out) exp_q.push_back(ent(ch, i == 0, i == n - 1, base + 32'(i)));
      csr_write(pdr_a(ch), base + 32'(i));
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] rd;

    fork
      begin : monitor
        logic [W-1:0] prev;
        logic         prev_stall;
        prev = '0;
        prev_stall = 1'b0;
        forever begin
          @(negedge clk);
          if (reset) begin
            prev_stall = 1'b0;
          end else begin
            if (prev_stall)
              check("stall_stable", 64'({tx_valid, tx_ch, tx_sop, tx_eop, tx_data}),
                    64'({1'b1, prev}));
            if (tx_valid && tx_ready) begin
              if (exp_q.size() == 0)
                check("unexpected_dword", 64'(exp_q.size()), 64'd1);
              else
                check("stream", 64'({tx_ch, tx_sop, tx_eop, tx_data}), 64'(exp_q.pop_front()));
            end
            prev_stall = tx_valid && !tx_ready;
            prev = {tx_ch, tx_sop, tx_eop, tx_data};
          end
        end
      end
    join_none

    // reset state
    repeat (3) tick();
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_err_irq", 64'(err_irq), 64'd0);
    check("rst_rvalid", 64'(csr_rvalid), 64'd0);
    check("rst_rdata", 64'(csr_rdata), 64'd0);
    reset = 1'b0;
    tick();

    // 1: single 3-dword packet on ch0
    tx_ready = 1'b1;
    send_pkt(0, 3, 32'hA000_0000, 1'b1);
    csr_write(fcr_a(0), 32'h1);
    wait_drain("t1_drain", 20);
    csr_read(fcr_a(0), rd);
    check("t1_fcr0", 64'(rd), 64'h0000_0080);

    // 2: ch0 and ch1 committed back to back, no interleave, no bubble
    send_pkt(0, 2, 32'hB000_0000, 1'b1);
    send_pkt(1, 2, 32'hB100_0000, 1'b1);
    csr_write(fcr_a(0), 32'h1);
    csr_write(fcr_a(1), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_no_bubble", 64'(tx_valid), 64'd1);
    end
    tick();
    wait_drain("t2_drain", 20);

    // 3: 65 dwords on ch1 overflow the packet limit
    send_pkt(1, 65, 32'hC000_0000, 1'b0);
    csr_write(fcr_a(1), 32'h1);
    repeat (6) tick();
    check("t3_no_stream", 64'(tx_valid), 64'd0);
    csr_read(12'h100, rd);
    check("t3_sts_ovf1", 64'(rd), 64'h0000_0002);
    csr_read(12'h104, rd);
    check("t3_drop_cnt", 64'(rd), 64'd1);
    check("t3_irq_set", 64'(err_irq), 64'd1);
    csr_read(fcr_a(1), rd);
    check("t3_fcr1_free", 64'(rd), 64'h0000_0080);
    csr_write(12'h100, 32'h2);
    check("t3_irq_clr", 64'(err_irq), 64'd0);

    // 4: five 1-dword packets on ch0 with the stream stalled
    tx_ready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      send_pkt(0, 1, 32'hD000_0000 + 32'(p), p < 4);
      csr_write(fcr_a(0), 32'h1);
    end
    csr_read(fcr_a(0), rd);
    check("t4_queued", 64'(rd[23:16]), 64'd4);
    csr_read(12'h100, rd);
    check("t4_sts_qfull0", 64'(rd), 64'h0001_0000);
    csr_read(12'h104, rd);
    check("t4_drop_cnt", 64'(rd), 64'd2);
    tx_ready = 1'b1;
    wait_drain("t4_drain", 20);
    repeat (3) tick();
    check("t4_idle", 64'(tx_valid), 64'd0);
    csr_write(12'h100, 32'h00FF_FFFF);

    // 5: abort, then commit of an empty packet
    send_pkt(0, 3, 32'hE000_0000, 1'b0);
    csr_write(fcr_a(0), 32'h3);
    csr_read(fcr_a(0), rd);
    check("t5_fcr0_abort", 64'(rd), 64'h0000_0080);
    csr_read(12'h104, rd);
    check("t5_drop_same", 64'(rd), 64'd2);
    csr_write(fcr_a(0), 32'h1);
    csr_read(12'h100, rd);
    check("t5_sts_badc0", 64'(rd), 64'h0000_0100);
    check("t5_irq_set", 64'(err_irq), 64'd1);
    csr_write(12'h108, 32'h100);
    check("t5_irq_masked", 64'(err_irq), 64'd0);
    csr_read(12'h108, rd);
    check("t5_mask_rd", 64'(rd), 64'h0000_0100);
    csr_read(12'h00C, rd);
    check("t5_unmapped_rd", 64'(rd), 64'd0);
    csr_write(12'h108, 32'h0);
    csr_write(12'h100, 32'h00FF_FFFF);

    // 6: random backpressure, then reset mid-packet
    tx_ready = 1'b0;
    send_pkt(0, 10, 32'hF000_0000, 1'b1);
    csr_write(fcr_a(0), 32'h1);
    send_pkt(1, 12, 32'hF100_0000, 1'b1);
    csr_write(fcr_a(1), 32'h1);
    for (int i = 0; i < 14; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 1'b1;
    exp_q.delete();
    tick();
    check("t6_rst_valid", 64'(tx_valid), 64'd0);
    check("t6_rst_eop", 64'(tx_eop), 64'd0);
    check("t6_rst_sop", 64'(tx_sop), 64'd0);
    check("t6_rst_data", 64'(tx_data), 64'd0);
    check("t6_rst_irq", 64'(err_irq), 64'd0);
    reset = 1'b0;
    tx_ready = 1'b1;
    tick();
    csr_read(fcr_a(0), rd);
    check("t6_fcr0_free", 64'(rd), 64'h0000_0080);
    csr_read(fcr_a(1), rd);
    check("t6_fcr1_free", 64'(rd), 64'h0000_0080);
    csr_read(12'h104, rd);
    check("t6_drop_clr", 64'(rd), 64'd0);
    repeat (4) tick();
    check("t6_idle", 64'(tx_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
